// File: rtl/stepper_axis_arbiter.sv
// Single-axis stepper controller: arbitrates manual buttons against CPU move
// commands and produces a settled direction level plus a timed step pulse train.
module stepper_axis_arbiter #(
    parameter int unsigned TICK_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 100000,
    parameter int unsigned SPD_W         = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             btn_fwd,
    input  logic             btn_rev,
    input  logic [SPD_W-1:0] man_speed,
    input  logic             cpu_cmd_valid,
    output logic             cpu_cmd_ready,
    input  logic             cpu_dir,
    input  logic [SPD_W-1:0] cpu_speed,
    input  logic [CNT_W-1:0] cpu_steps,
    input  logic             cpu_abort,
    output logic             step_out,
    output logic             dir_out,
    output logic [1:0]       owner,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);
    localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_MAN  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;

    typedef enum logic [1:0] {IDLE, SETTLE, STEP_HI, STEP_LO} state_t;

    state_t           state_q, state_n;
    logic             fwd_s1, rev_s1, fwd_s2, man_req_q;
    logic             dir_q, dir_n;
    logic [1:0]       owner_q, owner_n;
    logic [SPD_W-1:0] speed_q, speed_n;
    logic [CNT_W-1:0] steps_q, steps_n;
    logic [PRE_W-1:0] pre_q, pre_n;
    logic [SPD_W-1:0] tick_q, tick_n;
    logic [SET_W-1:0] settle_q, settle_n;
    logic             seen_q, seen_n;
    logic             done_q, done_n;
    logic             aborted_q, aborted_n;
    logic             step_q, step_n;
    logic             busy_q, busy_n;
    logic             ready_q, ready_n;

    // man_req_n is the value man_req_q takes next edge, so ready never overlaps a manual win
    logic man_req_n, man_go, half_end, abort_now;
    assign man_req_n = (fwd_s1 ^ rev_s1) && (man_speed != '0);
    assign man_go    = man_req_q && (man_speed != '0);
    assign half_end  = (pre_q == PRE_LAST) && (tick_q == speed_q - SPD_W'(1));
    assign abort_now = seen_q || cpu_abort || man_req_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            fwd_s1    <= 1'b0;
            rev_s1    <= 1'b0;
            fwd_s2    <= 1'b0;
            man_req_q <= 1'b0;
            dir_q     <= 1'b0;
            owner_q   <= OWN_NONE;
            speed_q   <= '0;
            steps_q   <= '0;
            pre_q     <= '0;
            tick_q    <= '0;
            settle_q  <= '0;
            seen_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            fwd_s1    <= btn_fwd;
            rev_s1    <= btn_rev;
            fwd_s2    <= fwd_s1;
            man_req_q <= man_req_n;
            dir_q     <= dir_n;
            owner_q   <= owner_n;
            speed_q   <= speed_n;
            steps_q   <= steps_n;
            pre_q     <= pre_n;
            tick_q    <= tick_n;
            settle_q  <= settle_n;
            seen_q    <= seen_n;
            done_q    <= done_n;
            aborted_q <= aborted_n;
            step_q    <= step_n;
            busy_q    <= busy_n;
            ready_q   <= ready_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        dir_n     = dir_q;
        owner_n   = owner_q;
        speed_n   = speed_q;
        steps_n   = steps_q;
        seen_n    = seen_q;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        pre_n     = '0;
        tick_n    = '0;
        settle_n  = '0;

        // half-period timing: prescaler wraps every TICK_CYCLES, tick counts speed
        if (state_q == STEP_HI || state_q == STEP_LO) begin
            if (pre_q == PRE_LAST) begin
                tick_n = tick_q + SPD_W'(1);
            end else begin
                pre_n  = pre_q + PRE_W'(1);
                tick_n = tick_q;
            end
        end
        if (state_q == SETTLE) begin
            settle_n = settle_q + SET_W'(1);
        end

        // abort/preempt is remembered until the end of the current step
        if (state_q != IDLE && owner_q == OWN_CPU && (cpu_abort || man_req_q)) begin
            seen_n = 1'b1;
        end

        case (state_q)
            IDLE: begin
                seen_n = 1'b0;
                if (man_go) begin
                    owner_n = OWN_MAN;
                    if (fwd_s2 != dir_q) begin
                        state_n = SETTLE;
                        dir_n   = fwd_s2;
                    end else begin
                        state_n = STEP_HI;
                        speed_n = man_speed;
                    end
                end else if (cpu_cmd_valid && ready_q) begin
                    steps_n = cpu_steps;
                    speed_n = cpu_speed;
                    if (cpu_steps == '0 || cpu_speed == '0) begin
                        done_n = 1'b1;
                    end else begin
                        owner_n = OWN_CPU;
                        if (cpu_dir != dir_q) begin
                            state_n = SETTLE;
                            dir_n   = cpu_dir;
                        end else begin
                            state_n = STEP_HI;
                        end
                    end
                end
            end
            SETTLE: begin
                if (settle_q == SET_LAST) begin
                    if (owner_q == OWN_MAN) begin
                        if (man_speed != '0) begin
                            state_n = STEP_HI;
                            speed_n = man_speed;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = STEP_HI;
                    end
                end
            end
            STEP_HI: begin
                if (half_end) begin
                    state_n = STEP_LO;
                    if (owner_q == OWN_CPU) begin
                        steps_n = steps_q - CNT_W'(1);
                    end
                end
            end
            STEP_LO: begin
                if (half_end) begin
                    if (owner_q == OWN_CPU) begin
                        if (steps_q == '0) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else if (abort_now) begin
                            state_n   = IDLE;
                            done_n    = 1'b1;
                            aborted_n = 1'b1;
                        end else begin
                            state_n = STEP_HI;
                        end
                    end else if (man_go && fwd_s2 == dir_q) begin
                        state_n = STEP_HI;
                        speed_n = man_speed;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state_q) begin
            pre_n    = '0;
            tick_n   = '0;
            settle_n = '0;
        end
        if (state_n == IDLE) begin
            owner_n = OWN_NONE;
        end

        step_n  = (state_n == STEP_HI);
        busy_n  = (state_n != IDLE);
        ready_n = (state_n == IDLE) && !man_req_n;
    end

    assign cpu_cmd_ready = ready_q;
    assign step_out      = step_q;
    assign dir_out       = dir_q;
    assign owner         = owner_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign steps_left    = steps_q;

endmodule

// File: tb/tb_stepper_axis_arbiter.sv
// Bench for stepper_axis_arbiter: a trace model predicts per-cycle outputs of each
// move from the timing rules; directed scenarios add literal spot checks.
module tb_stepper_axis_arbiter;
    localparam int unsigned TICK   = 2;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned SPD_W  = 16;
    localparam int unsigned CNT_W  = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             btn_fwd, btn_rev, cpu_cmd_valid, cpu_dir, cpu_abort;
    logic [SPD_W-1:0] man_speed, cpu_speed;
    logic [CNT_W-1:0] cpu_steps;
    logic             cpu_cmd_ready, step_out, dir_out, busy, done, aborted;
    logic [1:0]       owner;
    logic [CNT_W-1:0] steps_left;

    stepper_axis_arbiter #(
        .TICK_CYCLES(TICK), .SETTLE_CYCLES(SETTLE), .SPD_W(SPD_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .btn_fwd(btn_fwd), .btn_rev(btn_rev),
        .man_speed(man_speed), .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready),
        .cpu_dir(cpu_dir), .cpu_speed(cpu_speed), .cpu_steps(cpu_steps), .cpu_abort(cpu_abort),
        .step_out(step_out), .dir_out(dir_out), .owner(owner), .busy(busy), .done(done),
        .aborted(aborted), .steps_left(steps_left)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        step;
        logic        dir;
        logic [1:0]  own;
        logic        busy;
        logic        done;
        logic        ab;
        logic        rdy;
        logic [15:0] left;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   gen_total = 0;
    int   gen_left = 1000;
    logic model_dir = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    function automatic rec_t mk(input logic st, input logic d, input logic [1:0] o, input logic b,
                                input logic dn, input logic ab, input logic rd, input int left);
        mk = {st, d, o, b, dn, ab, rd, 16'(left)};
    endfunction

    task automatic add(input rec_t r);
        gen_total++;
        if (gen_left > 0) begin
            exp_q.push_back(r);
            gen_left--;
        end
    endtask

    // expected output trace of one CPU move, starting the cycle after the handshake
    task automatic gen_move(input logic d, input int s, input int n, input int a,
                            input logic rdy_end, input bit trail);
        int hp;
        int m;
        gen_total = 0;
        if (n == 0 || s == 0) begin
            add(mk(1'b0, model_dir, 2'd0, 1'b0, 1'b1, 1'b0, rdy_end, n));
            if (trail) add(mk(1'b0, model_dir, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, n));
        end else begin
            hp = s * int'(TICK);
            if (d != model_dir) begin
                model_dir = d;
                for (int i = 0; i < int'(SETTLE); i++) add(mk(1'b0, d, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, n));
            end
            m = (a > 0 && a < n) ? a : n;
            for (int i = 1; i <= m; i++) begin
                for (int k = 0; k < hp; k++) add(mk(1'b1, d, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, n - i + 1));
                for (int k = 0; k < hp; k++) add(mk(1'b0, d, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, n - i));
            end
            add(mk(1'b0, d, 2'd0, 1'b0, 1'b1, (m < n), rdy_end, n - m));
            if (trail) add(mk(1'b0, d, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, n - m));
        end
    endtask

    task automatic gen_manual(input int periods, input int s, input int left);
        for (int p = 0; p < periods; p++) begin
            for (int k = 0; k < s * int'(TICK); k++) add(mk(1'b1, model_dir, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, left));
            for (int k = 0; k < s * int'(TICK); k++) add(mk(1'b0, model_dir, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, left));
        end
    endtask

    // called at a negedge; the handshake happens at the next posedge
    task automatic do_cmd(input logic d, input int s, input int n);
        chk("ready_before_accept", 32'(cpu_cmd_ready), 32'd1);
        cpu_dir       = d;
        cpu_speed     = 16'(s);
        cpu_steps     = 16'(n);
        cpu_cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cpu_cmd_valid = 1'b0;
    endtask

    task automatic wait_q_empty(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk(nm, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    always begin : cmp
        rec_t e;
        rec_t a;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {step_out, dir_out, owner, busy, done, aborted, cpu_cmd_ready, steps_left};
            chk("trace", 32'(a), 32'(e));
        end
    end

    initial begin
        int k;
        btn_fwd = 1'b0; btn_rev = 1'b0; cpu_cmd_valid = 1'b0; cpu_dir = 1'b0;
        cpu_abort = 1'b0; man_speed = 16'd1; cpu_speed = '0; cpu_steps = '0;

        #1 reset_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({step_out, dir_out, owner, busy, done, aborted}), 32'd0);
        chk("rst_ready", 32'(cpu_cmd_ready), 32'd0);
        chk("rst_steps_left", 32'(steps_left), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_dir = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 32'(cpu_cmd_ready), 32'd1);

        // settle + two 6/6 steps
        gen_move(1'b1, 3, 2, 0, 1'b1, 1'b1);
        chk("t1_trace_len", 32'(gen_total), 32'd30);
        do_cmd(1'b1, 3, 2);
        wait_q_empty("t1_timeout");
        chk("t1_dir", 32'(dir_out), 32'd1);

        // same direction, no settle, 2/2 pulse
        gen_move(1'b1, 1, 1, 0, 1'b1, 1'b1);
        chk("t2_trace_len", 32'(gen_total), 32'd6);
        do_cmd(1'b1, 1, 1);
        wait_q_empty("t2_timeout");

        // manual preempts a 10-step move during step 3
        man_speed = 16'd1;
        gen_move(1'b1, 2, 10, 3, 1'b0, 1'b0);
        chk("t3_trace_len", 32'(gen_total), 32'd25);
        gen_manual(2, 1, 7);
        do_cmd(1'b1, 2, 10);
        repeat (16) @(negedge clock);
        btn_fwd = 1'b1;
        wait_q_empty("t3_timeout");
        chk("t3_owner_manual", 32'(owner), 32'd1);
        chk("t3_steps_left", 32'(steps_left), 32'd7);
        btn_fwd = 1'b0;
        k = 0;
        while (busy && k < 50) begin @(negedge clock); k++; end
        chk("t3_release_idle", 32'(busy), 32'd0);
        chk("t3_owner_none", 32'(owner), 32'd0);

        // both buttons = no request; zero-step command accepted without motion
        btn_fwd = 1'b1; btn_rev = 1'b1;
        repeat (3) @(negedge clock);
        gen_move(1'b0, 2, 0, 0, 1'b1, 1'b1);
        chk("t4_trace_len", 32'(gen_total), 32'd2);
        do_cmd(1'b0, 2, 0);
        wait_q_empty("t4_timeout");
        chk("t4_dir_unchanged", 32'(dir_out), 32'd1);
        btn_fwd = 1'b0; btn_rev = 1'b0;
        repeat (3) @(negedge clock);

        // one-cycle abort during the first high phase of a 5-step move
        gen_move(1'b1, 2, 5, 1, 1'b1, 1'b1);
        chk("t5_trace_len", 32'(gen_total), 32'd10);
        do_cmd(1'b1, 2, 5);
        @(negedge clock);
        cpu_abort = 1'b1;
        @(negedge clock);
        cpu_abort = 1'b0;
        wait_q_empty("t5_timeout");
        chk("t5_steps_left", 32'(steps_left), 32'd4);

        // reset asserted in STEP_HI after a settle to reverse
        gen_left = 6;
        gen_move(1'b0, 2, 3, 0, 1'b1, 1'b1);
        do_cmd(1'b0, 2, 3);
        repeat (5) @(negedge clock);
        chk("t6_in_step_hi", 32'(step_out), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_outputs", 32'({step_out, dir_out, owner, busy, done}), 32'd0);
        gen_left = 1000;
        model_dir = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("t6_ready_during_release", 32'(cpu_cmd_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("t6_ready_after_release", 32'(cpu_cmd_ready), 32'd1);
        chk("t6_no_done", 32'(done), 32'd0);
        @(negedge clock);

        // manual holds priority; a pending CPU command waits and then runs
        btn_rev = 1'b1;
        repeat (3) @(negedge clock);
        cpu_dir = 1'b0; cpu_speed = 16'd1; cpu_steps = 16'd1; cpu_cmd_valid = 1'b1;
        @(negedge clock);
        chk("t7_owner_manual", 32'(owner), 32'd1);
        chk("t7_ready_low", 32'(cpu_cmd_ready), 32'd0);
        btn_rev = 1'b0;
        k = 0;
        while (owner != 2'd2 && k < 50) begin @(negedge clock); k++; end
        cpu_cmd_valid = 1'b0;
        chk("t7_pending_accepted", 32'(owner), 32'd2);
        k = 0;
        while (!done && k < 50) begin @(negedge clock); k++; end
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_not_aborted", 32'(aborted), 32'd0);
        chk("t7_steps_left", 32'(steps_left), 32'd0);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
